// File: rtl/serial_rx_cfg.sv
// serial_rx_cfg: parametrised UART receiver with parity/framing/break detection and a ready/valid output buffer
module serial_rx_cfg #(
  parameter int CLK_PER_BIT = 100,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d, commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic break_det_q, break_det_d, overrun_q, overrun_d;
  logic rs, tick;
  assign rs = s2_q;
  assign tick = cnt_q == BIT_LAST;
  // Receive FSM: bit timing, LSB-first shifting and per-frame error accumulation
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    zero_d = zero_q;
    commit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
        state_d = rs ? IDLE : START;
      end
      START: if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        state_d = rs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = '0;
        sh_d = {rs, sh_q[DATA_BITS-1:1]};
        zero_d = zero_q & ~rs;
        idx_d = (idx_q == DATA_LAST) ? '0 : idx_q + 1'b1;
        state_d = (idx_q != DATA_LAST) ? DATA : (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (tick) begin
        cnt_d = '0;
        perr_d = (PARITY == 1) ? ~(^sh_q ^ rs) : (^sh_q ^ rs);
        zero_d = zero_q & ~rs;
        state_d = STOP;
      end
      STOP: if (tick) begin
        cnt_d = '0;
        ferr_d = ferr_q | ~rs;
        zero_d = zero_q & ~rs;
        idx_d = (idx_q == STOP_LAST) ? '0 : idx_q + 1'b1;
        commit_d = idx_q == STOP_LAST;
        state_d = (idx_q != STOP_LAST) ? STOP : (ferr_q | ~rs) ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        state_d = rs ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
  // Output buffer: load a finished frame when free or being drained, otherwise drop it and flag overrun
  always_comb begin
    data_d = data_q;
    parity_err_d = parity_err_q;
    frame_err_d = frame_err_q;
    break_det_d = break_det_q;
    valid_d = valid_q & ~ready;
    overrun_d = (valid_q & ready) ? 1'b0 : overrun_q;
    if (commit_q && (!valid_q || ready)) begin
      data_d = sh_q;
      parity_err_d = perr_q;
      frame_err_d = ferr_q;
      break_det_d = zero_q;
      valid_d = 1'b1;
      overrun_d = 1'b0;
    end else if (commit_q) begin
      overrun_d = 1'b1;
    end
  end
  // Synchronizer, receive state and output buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      zero_q <= 1'b0;
      commit_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      break_det_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      zero_q <= zero_d;
      commit_q <= commit_d;
      data_q <= data_d;
      valid_q <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q <= frame_err_d;
      break_det_q <= break_det_d;
      overrun_q <= overrun_d;
    end
  end
  assign data = data_q;
  assign valid = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err = frame_err_q;
  assign break_det = break_det_q;
  assign overrun = overrun_q;
endmodule
